// File: rtl/apu_link_pkg.sv
// Shared definitions for the nibble-encoded APU register link: the byte layout,
// the encoder, and the default clock/baud values that the receiver also uses.
package apu_link_pkg;

  localparam int DEF_CLK_HZ = 12_000_000;
  localparam int DEF_BAUD   = 9_600;

  // Nibble-byte layout: {0, addr[1:0], hi, nib[3:0]}
  localparam int ADDR_MSB = 6;
  localparam int ADDR_LSB = 5;
  localparam int HI_BIT   = 4;
  localparam int NIB_MSB  = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_BYTE0, WR_BYTE1} wr_state_e;

  function automatic logic [7:0] encode_nibble(input logic [1:0] addr, input logic hi,
                                               input logic [3:0] nib);
    logic [7:0] b;
    b                   = '0;
    b[ADDR_MSB:ADDR_LSB] = addr;
    b[HI_BIT]            = hi;
    b[NIB_MSB:0]         = nib;
    return b;
  endfunction

endpackage

// File: rtl/apu_reg_uart_tx_if.sv
// Register-write handshake between a host and the APU link transmitter.
interface apu_reg_uart_tx_if;
  logic       wr_valid;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// Generic 8N1/8N2 byte serializer. A load is taken while idle or on the final
// stop-bit clock, so consecutive bytes can be sent with no idle gap.
module uart_tx_byte
  import apu_link_pkg::*;
#(
  parameter int BAUD_DIV  = 1250,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  tx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign ready   = (state == TX_IDLE);
  // done marks the last clock of the last stop bit; a chained load lands here.
  assign done    = (state == TX_STOP) && bit_end && (bit_idx == 3'(STOP_BITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else if (load && (ready || done)) begin
      state    <= TX_START;
      tx       <= 1'b0;
      shift    <= data;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        TX_IDLE: tx <= 1'b1;
        TX_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= TX_DATA;
            tx       <= shift[0];
          end else baud_cnt <= baud_cnt + CNT_W'(1);
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= TX_STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else baud_cnt <= baud_cnt + CNT_W'(1);
        end
        TX_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (done) state <= TX_IDLE;
            else      bit_idx <= bit_idx + 3'd1;
          end else baud_cnt <= baud_cnt + CNT_W'(1);
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apu_reg_uart_tx.sv
// APU register-write transmitter: accepts one (addr, data) write and sends it
// as two nibble bytes, low nibble first, through a shared byte serializer.
module apu_reg_uart_tx
  import apu_link_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int BAUD      = DEF_BAUD,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  apu_reg_uart_tx_if.slave    wr,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("apu_reg_uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("apu_reg_uart_tx: STOP_BITS must be 1 or 2");
  end

  wr_state_e  state;
  logic       ready_q;
  logic [1:0] addr_q;
  logic [3:0] hi_nib_q;
  logic       accept;
  logic       load;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_done;

  assign wr.wr_ready = ready_q;
  assign accept      = wr.wr_valid && ready_q && byte_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    load      = 1'b0;
    byte_data = encode_nibble(wr.wr_addr, 1'b0, wr.wr_data[3:0]);
    case (state)
      WR_IDLE:  load = accept;
      WR_BYTE0: begin
        load      = byte_done;
        byte_data = encode_nibble(addr_q, 1'b1, hi_nib_q);
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WR_IDLE;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_q   <= '0;
      hi_nib_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        WR_IDLE: begin
          if (accept) begin
            state    <= WR_BYTE0;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            addr_q   <= wr.wr_addr;
            hi_nib_q <= wr.wr_data[7:4];
          end
        end
        WR_BYTE0: if (byte_done) state <= WR_BYTE1;
        WR_BYTE1: begin
          if (byte_done) begin
            state   <= WR_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV  (BAUD_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (byte_data),
    .ready (byte_ready),
    .done  (byte_done),
    .tx    (tx)
  );

endmodule
